// File: rtl/fft_peak_detect.sv
// Streaming peak finder for the FFT output: approximate |X[k]| per bin, track the
// strongest positive-frequency bin, report once per frame. Optional FFT_PEAK_SPECTRUM_EN exposes per-bin magnitudes.
module fft_peak_detect #(
  parameter int WIDTH   = 16,
  parameter int M       = 9,
  parameter int MIN_BIN = 1,
  parameter int THRESH  = 64
) (
  input  logic               clk_slow,
  input  logic               reset,
  input  logic               done,
  input  logic [2*WIDTH-1:0] wd,
  output logic               peak_valid,
  output logic [M-1:0]       peak_bin,
  output logic [WIDTH:0]     peak_mag,
  output logic               peak_found,
  output logic               busy
`ifdef FFT_PEAK_SPECTRUM_EN
  ,
  output logic               mag_valid,
  output logic [M-1:0]       mag_bin,
  output logic [WIDTH:0]     mag_out
`endif
);

  localparam int              POINTS     = 2**M;
  localparam logic [M-1:0]    LAST_BIN   = M'(POINTS - 1);
  localparam logic [M-1:0]    BAND_LO    = M'(MIN_BIN);
  localparam logic [M-1:0]    BAND_HI    = M'(POINTS / 2 - 1);
  localparam logic [WIDTH:0]  THRESH_MAG = (WIDTH+1)'(THRESH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, WAITLOW} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic             w_first;
  logic             w_flush;
  logic             w_finish;
  logic [M-1:0]     w_tag;
  logic [M-1:0]     r_bin_cnt;

  logic             r_s1_vld;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [M-1:0]     r_s1_tag;

  logic             r_s2_vld;
  logic [WIDTH:0]   r_s2_mag;
  logic [M-1:0]     r_s2_tag;

  logic [WIDTH:0]   r_run_max;
  logic [M-1:0]     r_run_bin;

  logic             r_peak_valid;
  logic [M-1:0]     r_peak_bin;
  logic [WIDTH:0]   r_peak_mag;
  logic             r_peak_found;

  logic [WIDTH-1:0] w_abs [2];
  logic [WIDTH-1:0] w_mx;
  logic [WIDTH-1:0] w_mn;
  logic [WIDTH:0]   w_mag;
  logic             w_in_band;

  always_ff @(posedge clk_slow) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_first      = 1'b0;
    w_flush      = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (done) begin
          w_accept     = 1'b1;
          w_first      = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (done) begin
          w_accept = 1'b1;
          if (r_bin_cnt == LAST_BIN) w_state_next = DRAIN;
        end else begin
          w_flush      = 1'b1;
          w_state_next = IDLE;
        end
      end
      DRAIN: begin
        // S3 has absorbed the last beat once both earlier stages are empty
        if (!r_s1_vld && !r_s2_vld) begin
          w_finish     = 1'b1;
          w_state_next = WAITLOW;
        end
      end
      WAITLOW: begin
        if (!done) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_tag = w_first ? '0 : r_bin_cnt;

  // Two's-complement absolute value; the most negative input maps to 2**(WIDTH-1)
  for (genvar gi = 0; gi < 2; gi++) begin : g_abs
    logic [WIDTH-1:0] w_comp;
    assign w_comp    = wd[gi*WIDTH +: WIDTH];
    assign w_abs[gi] = w_comp[WIDTH-1] ? (~w_comp + 1'b1) : w_comp;
  end

  assign w_mx  = (r_s1_a >= r_s1_b) ? r_s1_a : r_s1_b;
  assign w_mn  = (r_s1_a >= r_s1_b) ? r_s1_b : r_s1_a;
  assign w_mag = {1'b0, w_mx} + {3'b000, w_mn[WIDTH-1:2]} + {4'b0000, w_mn[WIDTH-1:3]};

  assign w_in_band = (r_s2_tag >= BAND_LO) && (r_s2_tag <= BAND_HI);

  always_ff @(posedge clk_slow) begin
    if (reset) begin
      r_bin_cnt    <= '0;
      r_s1_vld     <= 1'b0;
      r_s1_a       <= '0;
      r_s1_b       <= '0;
      r_s1_tag     <= '0;
      r_s2_vld     <= 1'b0;
      r_s2_mag     <= '0;
      r_s2_tag     <= '0;
      r_run_max    <= '0;
      r_run_bin    <= BAND_LO;
      r_peak_valid <= 1'b0;
      r_peak_bin   <= '0;
      r_peak_mag   <= '0;
      r_peak_found <= 1'b0;
    end else begin
      if (w_accept)     r_bin_cnt <= w_tag + 1'b1;
      else if (w_flush) r_bin_cnt <= '0;

      r_s1_vld <= w_accept;
      r_s1_a   <= w_abs[1];
      r_s1_b   <= w_abs[0];
      r_s1_tag <= w_tag;

      r_s2_vld <= r_s1_vld && !w_flush;
      r_s2_mag <= w_mag;
      r_s2_tag <= r_s1_tag;

      if (w_first) begin
        r_run_max <= '0;
        r_run_bin <= BAND_LO;
      end else if (r_s2_vld && w_in_band && (r_s2_mag > r_run_max)) begin
        r_run_max <= r_s2_mag;
        r_run_bin <= r_s2_tag;
      end

      r_peak_valid <= w_finish;
      if (w_finish) begin
        r_peak_bin   <= r_run_bin;
        r_peak_mag   <= r_run_max;
        r_peak_found <= (r_run_max >= THRESH_MAG);
      end
    end
  end

  assign peak_valid = r_peak_valid;
  assign peak_bin   = r_peak_bin;
  assign peak_mag   = r_peak_mag;
  assign peak_found = r_peak_found;
  assign busy       = (r_state != IDLE);

`ifdef FFT_PEAK_SPECTRUM_EN
  assign mag_valid = r_s2_vld;
  assign mag_bin   = r_s2_tag;
  assign mag_out   = r_s2_mag;
`endif

endmodule

// File: tb/tb_fft_peak_detect.sv
// Self-checking bench for fft_peak_detect: directed and random frames compared
// against an arithmetic reference of the peak search.
module tb_fft_peak_detect;
  localparam int WIDTH   = 16;
  localparam int M       = 9;
  localparam int POINTS  = 512;
  localparam int MIN_BIN = 1;
  localparam int THRESH  = 64;

  logic               clk_slow = 1'b0;
  logic               reset    = 1'b1;
  logic               done     = 1'b0;
  logic [2*WIDTH-1:0] wd       = '0;
  logic               peak_valid;
  logic [M-1:0]       peak_bin;
  logic [WIDTH:0]     peak_mag;
  logic               peak_found;
  logic               busy;
`ifdef FFT_PEAK_SPECTRUM_EN
  logic               mag_valid;
  logic [M-1:0]       mag_bin;
  logic [WIDTH:0]     mag_out;
`endif

  fft_peak_detect #(.WIDTH(WIDTH), .M(M), .MIN_BIN(MIN_BIN), .THRESH(THRESH)) dut (
    .clk_slow   (clk_slow),
    .reset      (reset),
    .done       (done),
    .wd         (wd),
    .peak_valid (peak_valid),
    .peak_bin   (peak_bin),
    .peak_mag   (peak_mag),
    .peak_found (peak_found),
    .busy       (busy)
`ifdef FFT_PEAK_SPECTRUM_EN
    ,
    .mag_valid  (mag_valid),
    .mag_bin    (mag_bin),
    .mag_out    (mag_out)
`endif
  );

  always #5 clk_slow = ~clk_slow;

  int re_arr [POINTS];
  int im_arr [POINTS];
  int checks   = 0;
  int errors   = 0;
  int edge_cnt = 0;
  int pv_count = 0;
  int pv_edge  = 0;
  int exp_bin;
  int exp_mag;
  int exp_found;

  always @(posedge clk_slow) edge_cnt = edge_cnt + 1;

  always @(negedge clk_slow) begin
    if (peak_valid === 1'b1) begin
      pv_count = pv_count + 1;
      pv_edge  = edge_cnt;
    end
  end

`ifdef FFT_PEAK_SPECTRUM_EN
  int mv_count    = 0;
  int mv_next_bin = 0;
  int mv_seq_err  = 0;
  always @(negedge clk_slow) begin
    if (mag_valid === 1'b1) begin
      if (int'(mag_bin) != mv_next_bin) mv_seq_err = mv_seq_err + 1;
      mv_next_bin = (mv_next_bin + 1) % POINTS;
      mv_count    = mv_count + 1;
    end
  end
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks = checks + 1;
    assert (obs === expv) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: |z| ~ max + min/4 + min/8 over bins MIN_BIN..POINTS/2-1, first maximum wins
  task automatic model();
    int best, bb, a, b, mx, mn, mag;
    best = 0;
    bb   = MIN_BIN;
    for (int k = MIN_BIN; k <= POINTS/2 - 1; k++) begin
      a   = (re_arr[k] < 0) ? -re_arr[k] : re_arr[k];
      b   = (im_arr[k] < 0) ? -im_arr[k] : im_arr[k];
      mx  = (a > b) ? a : b;
      mn  = (a > b) ? b : a;
      mag = mx + mn / 4 + mn / 8;
      if (mag > best) begin
        best = mag;
        bb   = k;
      end
    end
    exp_bin   = bb;
    exp_mag   = best;
    exp_found = (best >= THRESH) ? 1 : 0;
  endtask

  task automatic clear_frame();
    for (int k = 0; k < POINTS; k++) begin
      re_arr[k] = 0;
      im_arr[k] = 0;
    end
  endtask

  task automatic rand_frame();
    int b1, b2, v;
    for (int k = 0; k < POINTS; k++) begin
      re_arr[k] = int'($urandom_range(0, 1000)) - 500;
      im_arr[k] = int'($urandom_range(0, 1000)) - 500;
    end
    b1 = int'($urandom_range(MIN_BIN, POINTS/2 - 1));
    b2 = int'($urandom_range(MIN_BIN, POINTS/2 - 1));
    v  = int'($urandom_range(500, 32767));
    re_arr[b1] = v;  im_arr[b1] = 0;
    re_arr[b2] = -v; im_arr[b2] = 0;
    re_arr[0]   = 32767;
    re_arr[300] = -32768;
  endtask

  task automatic drive_beat(input int k);
    logic [WIDTH-1:0] r16, i16;
    r16 = WIDTH'(re_arr[k]);
    i16 = WIDTH'(im_arr[k]);
    wd  = {r16, i16};
  endtask

  // Presents beats 0..nbeats-1, then holds done for extra cycles; returns the edge index sampling the last beat
  task automatic send(input int nbeats, input int extra, output int last_edge);
    for (int k = 0; k < nbeats; k++) begin
      @(posedge clk_slow); #1;
      done = 1'b1;
      drive_beat(k);
    end
    @(posedge clk_slow); #1;
    last_edge = edge_cnt;
    for (int e = 0; e < extra; e++) begin
      wd = $urandom;
      @(posedge clk_slow); #1;
    end
    done = 1'b0;
    wd   = '0;
  endtask

  task automatic full_frame(input string name, input int extra);
    int e, pv0;
    model();
    pv0 = pv_count;
`ifdef FFT_PEAK_SPECTRUM_EN
    int mv0;
    mv0 = mv_count;
    mv_next_bin = 0;
    mv_seq_err  = 0;
`endif
    send(POINTS, extra, e);
    repeat (6) @(posedge clk_slow);
    #1;
    check({name, " pulses"}, 32'(pv_count - pv0), 32'd1);
    check({name, " latency"}, 32'(pv_edge), 32'(e + 3));
    check({name, " bin"}, 32'(peak_bin), 32'(exp_bin));
    check({name, " mag"}, 32'(peak_mag), 32'(exp_mag));
    check({name, " found"}, 32'(peak_found), 32'(exp_found));
    check({name, " busy"}, 32'(busy), 32'd0);
    $display("frame %s: bin=%0d mag=%0d found=%0d (expected %0d/%0d/%0d)",
             name, peak_bin, peak_mag, peak_found, exp_bin, exp_mag, exp_found);
`ifdef FFT_PEAK_SPECTRUM_EN
    check({name, " mag_valid count"}, 32'(mv_count - mv0), 32'(POINTS));
    check({name, " mag_bin order"}, 32'(mv_seq_err), 32'd0);
`endif
  endtask

  initial begin
    int e, pv0, hold_bin, hold_mag, hold_found;

    repeat (3) @(posedge clk_slow);
    #1;
    check("reset peak_valid", 32'(peak_valid), 32'd0);
    check("reset peak_bin", 32'(peak_bin), 32'd0);
    check("reset peak_mag", 32'(peak_mag), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(posedge clk_slow); #1;

    clear_frame(); re_arr[37] = 1000;
    full_frame("single37", 0);

    clear_frame(); re_arr[10] = 300; im_arr[10] = -400; re_arr[20] = 500;
    full_frame("approx10", 0);

    clear_frame();
    re_arr[5] = 800; re_arr[9] = 800; re_arr[0] = 30000; re_arr[400] = 20000; re_arr[50] = 40;
    full_frame("tie_band", 0);

    clear_frame(); re_arr[50] = 40;
    full_frame("below_thresh", 0);

    clear_frame();
    full_frame("all_zero", 0);

    clear_frame(); re_arr[3] = -32768; im_arr[3] = -32768;
    full_frame("most_neg", 0);

    // Abort after beat 200: no pulse, outputs keep the previous frame's result
    hold_bin = int'(peak_bin); hold_mag = int'(peak_mag); hold_found = int'(peak_found);
    clear_frame(); re_arr[7] = 500;
    pv0 = pv_count;
    send(201, 0, e);
    repeat (8) @(posedge clk_slow);
    #1;
    check("abort pulses", 32'(pv_count - pv0), 32'd0);
    check("abort bin held", 32'(peak_bin), 32'(hold_bin));
    check("abort mag held", 32'(peak_mag), 32'(hold_mag));
    check("abort found held", 32'(peak_found), 32'(hold_found));
    check("abort busy", 32'(busy), 32'd0);
    $display("abort: bin=%0d mag=%0d pulses=%0d", peak_bin, peak_mag, pv_count - pv0);

    clear_frame(); re_arr[7] = 99;
    full_frame("after_abort", 0);

    rand_frame();
    full_frame("hold600", 600 - POINTS);

    // Reset asserted at beat 100 clears outputs on the next cycle
    rand_frame();
    pv0 = pv_count;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk_slow); #1;
      done = 1'b1;
      drive_beat(k);
    end
    @(posedge clk_slow); #1;
    check("midframe busy", 32'(busy), 32'd1);
    reset = 1'b1;
    done  = 1'b0;
    @(posedge clk_slow); #1;
    check("midreset peak_bin", 32'(peak_bin), 32'd0);
    check("midreset peak_mag", 32'(peak_mag), 32'd0);
    check("midreset peak_found", 32'(peak_found), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (4) @(posedge clk_slow);
    #1;
    check("midreset pulses", 32'(pv_count - pv0), 32'd0);
    $display("midframe reset: bin=%0d mag=%0d busy=%0d", peak_bin, peak_mag, busy);
    full_frame("after_reset", 0);

    for (int f = 0; f < 3; f++) begin
      rand_frame();
      full_frame($sformatf("random%0d", f), int'($urandom_range(0, 20)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
